// File: rtl/mul_hilo_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mul_hilo_ctrl_pkg
// Shared definitions for the multiply issue/writeback controller:
//   - state_t      : controller FSM encoding (IDLE / RUN / CAPTURE)
//   - MUL_LATENCY  : cycles from operand launch to a valid product
//   - HILO_SEL_*   : bit positions of HI and LO in the mthi/mtlo write mask,
//                    also used as the index of each register in hilo_regfile
// ----------------------------------------------------------------------------
package mul_hilo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam int MUL_LATENCY = 4;
  localparam int HILO_W      = 32;

  // Index 0 holds the low product word, index 1 the high word.
  localparam int HILO_SEL_LO = 0;
  localparam int HILO_SEL_HI = 1;

endpackage

// File: rtl/mul_hilo_ctrl_hilo_regfile.sv
// ----------------------------------------------------------------------------
// hilo_regfile
// Architectural HI/LO register pair.
//
// Optional build macro: MUL_HILO_WRITE_EN (adds the mthi/mtlo write port).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset, clears HI and LO
//   cap_en     in   load both registers from cap_data this edge
//   cap_data   in   64-bit product; [63:32] -> HI, [31:0] -> LO
//   wr_en      in   (MUL_HILO_WRITE_EN) per-register write mask, bit1 = HI
//   wr_data    in   (MUL_HILO_WRITE_EN) data for the selected register(s)
//   hi, lo     out  current register contents
// ----------------------------------------------------------------------------
module hilo_regfile
  import mul_hilo_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cap_en,
  input  logic [2*HILO_W-1:0] cap_data,
`ifdef MUL_HILO_WRITE_EN
  input  logic [1:0]          wr_en,
  input  logic [HILO_W-1:0]   wr_data,
`endif
  output logic [HILO_W-1:0]   hi,
  output logic [HILO_W-1:0]   lo
);

  logic [HILO_W-1:0] hilo_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_hilo
    always_ff @(posedge clk) begin
      if (reset) begin
        hilo_reg[gi] <= '0;
      end else if (cap_en) begin
        // Capture wins; the controller never raises both in one cycle.
        hilo_reg[gi] <= cap_data[gi*HILO_W +: HILO_W];
`ifdef MUL_HILO_WRITE_EN
      end else if (wr_en[gi]) begin
        hilo_reg[gi] <= wr_data;
`endif
      end
    end
  end

  assign hi = hilo_reg[HILO_SEL_HI];
  assign lo = hilo_reg[HILO_SEL_LO];

endmodule

// File: rtl/mul_hilo_ctrl.sv
// ----------------------------------------------------------------------------
// mul_hilo_ctrl
// Issue and writeback controller for a pipelined signed 32x32 multiplier.
// Accepts one request at a time, holds the operands on the multiplier for the
// whole run, waits out the fixed latency and commits the product to HI/LO.
//
// Optional build macro: MUL_HILO_WRITE_EN (adds hilo_we / hilo_wdata for
// mthi/mtlo; writes are honoured only while IDLE).
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   mul_valid/mul_ready  request handshake from execute
//   mul_a, mul_b         operands, latched on accept
//   mult_start           high while the multiplier is running
//   mult_in1, mult_in2   operands held to the multiplier
//   mult_out             64-bit product from the multiplier
//   rd_hilo              decode has an mfhi/mflo in flight
//   stall                busy & rd_hilo
//   busy                 RUN or CAPTURE
//   done                 high in the CAPTURE cycle (HI/LO update at its end)
//   hi, lo               architectural HI/LO
//   hilo_we, hilo_wdata  (MUL_HILO_WRITE_EN) mthi/mtlo write port
// ----------------------------------------------------------------------------
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY,
  parameter int CNT_W   = 3            // 2**CNT_W must exceed LATENCY
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MUL_HILO_WRITE_EN
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
`endif
  input  logic        mul_valid,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  output logic        mul_ready,
  output logic        mult_start,
  output logic [31:0] mult_in1,
  output logic [31:0] mult_in2,
  input  logic [63:0] mult_out,
  input  logic        rd_hilo,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg,   cnt_next;
  logic [31:0]       in1_reg,   in1_next;
  logic [31:0]       in2_reg,   in2_next;
  logic              cap_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      in1_reg   <= '0;
      in2_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      in1_reg   <= in1_next;
      in2_reg   <= in2_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    in1_next   = in1_reg;
    in2_next   = in2_reg;
    mul_ready  = 1'b0;
    mult_start = 1'b0;
    busy       = 1'b0;
    cap_en     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        mul_ready = 1'b1;
        if (mul_valid) begin
          in1_next   = mul_a;
          in2_next   = mul_b;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        mult_start = 1'b1;
        busy       = 1'b1;
        cnt_next   = cnt_reg + 1'b1;
        // Operands launched at accept reach mult_out after LATENCY edges,
        // i.e. exactly during the following CAPTURE cycle.
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        busy       = 1'b1;
        cap_en     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mult_in1 = in1_reg;
  assign mult_in2 = in2_reg;
  assign stall    = busy & rd_hilo;
  // A reset landing on CAPTURE discards the product, so suppress the pulse.
  assign done     = cap_en & ~reset;

  hilo_regfile u_hilo (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .cap_data (mult_out),
`ifdef MUL_HILO_WRITE_EN
    // mthi/mtlo only take effect while no multiply owns HI/LO.
    .wr_en    ((state_reg == ST_IDLE) ? hilo_we : 2'b00),
    .wr_data  (hilo_wdata),
`endif
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
Issue and writeback controller for the signed 32x32 multiplier.
- Accepts a multiply request from the execute stage and holds the operands stable on the multiplier inputs.
- Asserts the multiplier start and counts out its fixed pipeline latency.
- Captures the 64-bit product into architectural HI/LO registers.
- Stalls mfhi/mflo consumers until the result is committed.

Parameters:
LATENCY, 4, clock cycles from operand launch to valid product on mult_out (the multiplier has 4 internal register stages).
CNT_W, 3, width of the latency counter; must satisfy 2^CNT_W > LATENCY.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
mul_valid  in  1  execute stage requests a multiply
mul_a  in  32  signed multiplicand
mul_b  in  32  signed multiplier
mul_ready  out  1  request accepted this cycle when mul_valid & mul_ready
mult_start  out  1  drives multiplier start
mult_in1  out  32  operand A held to multiplier
mult_in2  out  32  operand B held to multiplier
mult_out  in  64  product from multiplier
rd_hilo  in  1  decode stage has mfhi/mflo in flight
stall  out  1  freeze the pipeline front end
busy  out  1  multiply in progress
done  out  1  one-cycle pulse when HI/LO are updated
hi  out  32  HI register (product[63:32])
lo  out  32  LO register (product[31:0])

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, counter 0, mult_in1/mult_in2 = 0, mult_start = 0, busy = 0, done = 0, hi = 0, lo = 0. mul_ready = 1 in the cycle after reset deasserts.
- FSM states: IDLE, RUN, CAPTURE.
- IDLE:
  - mul_ready = 1.
  - When mul_valid is high, latch mul_a and mul_b into mult_in1/mult_in2, clear the counter and go to RUN.
- RUN:
  - mult_start = 1, busy = 1, mul_ready = 0.
  - The counter increments each cycle.
  - When counter == LATENCY-1, go to CAPTURE.
  - Operands stay constant for the whole of RUN.
- CAPTURE:
  - hi <= mult_out[63:32], lo <= mult_out[31:0].
  - done = 1 for this cycle only; busy = 1; mul_ready = 0.
  - Next state is IDLE.
- Latency: accept at edge N; HI/LO are visible at edge N+LATENCY+1. Next accept is possible at edge N+LATENCY+2.
- Stall: stall = busy & rd_hilo, combinational. It covers CAPTURE, so readers never see stale HI/LO.
- mul_valid while not ready is ignored. The requester must hold mul_valid until it sees mul_ready.
- Arithmetic: no width changes in this block; the product is taken as signed 64-bit verbatim.
- Reset mid-operation: aborts RUN or CAPTURE; HI/LO are cleared and no done pulse is emitted.
- Back-to-back: mul_valid held high through a completion is accepted in the IDLE cycle that follows CAPTURE.

Optional Feature:
Macro: MUL_HILO_WRITE_EN
- With the macro defined, extra ports are added: hilo_we in 2 (bit1 = HI, bit0 = LO) and hilo_wdata in 32. These support mthi/mtlo.
  - A write in IDLE updates the selected register at the next edge.
  - A write during RUN or CAPTURE is ignored.
  - If a write coincides with an accept in IDLE, the write takes effect, and the later product overwrites it.
- Without the macro, the ports are absent and HI/LO are written only by CAPTURE.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2), MUL_LATENCY = 4 constant, HILO_SEL_HI/HILO_SEL_LO bit indices.
- One sub-module, hilo_regfile: two 32-bit registers with synchronous reset, a capture port, and an optional mthi/mtlo write port.
- FSM and counter stay in the top module.

Test Plan:
- Reset then accept a=3, b=-5 (0xFFFFFFFB), multiplier model = 4-cycle delayed product -> done at accept+5; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; mul_ready low for exactly 5 cycles.
- a=0x80000000, b=0x80000000 with rd_hilo held high -> stall high from accept+1 through the CAPTURE cycle, low the cycle after; hi=0x40000000, lo=0.
- mul_valid held high across two requests (2*3, then -1*-1) -> second accept is in the IDLE cycle after the first done; final hi=0, lo=1.
- Reset asserted on the 2nd RUN cycle -> no done pulse, hi=lo=0, mul_ready=1 in the cycle after reset deasserts.
- With MUL_HILO_WRITE_EN: hilo_we=2'b10, hilo_wdata=0xDEADBEEF in IDLE -> hi=0xDEADBEEF and lo unchanged. The same write issued during RUN is ignored.
